mdlu_seq: RTL and testbench

Multi-cycle multiply/divide unit with architectural HI/LO registers. It is the parametrised successor of the single-op MDLU encoding. It adds unsigned variants, MTHI/MTLO, a start/busy/done handshake and a configurable datapath width. It sits beside the ALU in the MIPS datapath; the control unit stalls on busy, and MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/mdlu_seq_pkg.sv | 26 ++
 rtl/mdlu_seq_step.sv | 39 +++
 rtl/mdlu_seq.sv | 178 +++++++++++++++++
 tb/tb_mdlu_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdlu_seq_pkg.sv
// Shared operation codes, FSM states and opcode helpers for the mdlu_seq
// multiply/divide unit.
package libMdluSeq;

  // Codes 0-2 match the original single-op MDLU encoding.
  typedef enum logic [2:0] {
    MDLU_MULT  = 3'd0,
    MDLU_DIV   = 3'd1,
    MDLU_ZERO  = 3'd2,
    MDLU_MULTU = 3'd3,
    MDLU_DIVU  = 3'd4,
    MDLU_MTHI  = 3'd5,
    MDLU_MTLO  = 3'd6
  } mdlu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdlu_state_t;

  function automatic logic op_is_signed(input mdlu_op_t op);
    return (op == MDLU_MULT) || (op == MDLU_DIV);
  endfunction

endpackage

// File: rtl/mdlu_seq_step.sv
// One iteration of the unsigned magnitude datapath: shift-add multiply
// (mode_div=0) or restoring compare-subtract-shift divide (mode_div=1).
module mdlu_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic [2*WIDTH-1:0]   opa_next,
  output logic [WIDTH-1:0]     opb_next
);

  // Divide: acc[WIDTH-1:0] is the partial remainder, opa[WIDTH-1:0] the
  // divisor, opb shifts dividend bits out the top and quotient bits in.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    shifted  = {acc[WIDTH-1:0], opb[WIDTH-1]};
    borrow   = shifted < {1'b0, opa[WIDTH-1:0]};
    // Only used when no borrow, where the true difference fits in WIDTH bits.
    diff     = shifted[WIDTH-1:0] - opa[WIDTH-1:0];
    acc_next = acc;
    opa_next = opa;
    opb_next = opb;
    if (mode_div) begin
      acc_next = {{WIDTH{1'b0}}, (borrow ? shifted[WIDTH-1:0] : diff)};
      opb_next = {opb[WIDTH-2:0], ~borrow};
    end else begin
      acc_next = opb[0] ? (acc + opa) : acc;
      opa_next = opa << 1;
      opb_next = opb >> 1;
    end
  end

endmodule

// File: rtl/mdlu_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers and start/busy/done.
// Optional macro MDLU_EARLY_TERM_EN ends a multiply once the multiplier is exhausted.
module mdlu_seq
  import libMdluSeq::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  mdlu_op_t         op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdlu_state_t          state_reg, state_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [2*WIDTH-1:0]   opa_reg, opa_next;
  logic [WIDTH-1:0]     opb_reg, opb_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 div_reg, div_next;
  logic                 neg_lo_reg, neg_lo_next;
  logic                 neg_hi_reg, neg_hi_next;
  logic [WIDTH-1:0]     hi_reg, hi_next;
  logic [WIDTH-1:0]     lo_reg, lo_next;
  logic                 done_reg, done_next;

  logic [2*WIDTH-1:0]   step_acc, step_opa;
  logic [WIDTH-1:0]     step_opb;
  logic                 rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed, rem_fixed;

  mdlu_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (div_reg),
    .acc      (acc_reg),
    .opa      (opa_reg),
    .opb      (opb_reg),
    .acc_next (step_acc),
    .opa_next (step_opa),
    .opb_next (step_opb)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    neg_lo_next = neg_lo_reg;
    neg_hi_next = neg_hi_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;

    // Negating MIN yields 2^(WIDTH-1), which is exact as an unsigned value.
    rs_neg = op_is_signed(op) && rs[WIDTH-1];
    rt_neg = op_is_signed(op) && rt[WIDTH-1];
    rs_mag = rs_neg ? (~rs + 1'b1) : rs;
    rt_mag = rt_neg ? (~rt + 1'b1) : rt;

    prod_fixed = neg_lo_reg ? (~acc_reg + 1'b1) : acc_reg;
    quo_fixed  = neg_lo_reg ? (~opb_reg + 1'b1) : opb_reg;
    rem_fixed  = neg_hi_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];

    case (state_reg)
      IDLE: begin
        if (start) begin
          case (op)
            MDLU_MULT, MDLU_MULTU: begin
              acc_next    = '0;
              opa_next    = {{WIDTH{1'b0}}, rs_mag};
              opb_next    = rt_mag;
              cnt_next    = '0;
              div_next    = 1'b0;
              neg_lo_next = rs_neg ^ rt_neg;
              neg_hi_next = 1'b0;
              state_next  = RUN;
            end
            MDLU_DIV, MDLU_DIVU: begin
              acc_next    = '0;
              opa_next    = {{WIDTH{1'b0}}, rt_mag};
              opb_next    = rs_mag;
              cnt_next    = '0;
              div_next    = 1'b1;
              // A zero divisor leaves an all-ones quotient that must not be negated;
              // the remainder then equals |rs| and its sign fix restores rs.
              neg_lo_next = (rs_neg ^ rt_neg) && (rt != '0);
              neg_hi_next = rs_neg;
              state_next  = RUN;
            end
            MDLU_ZERO: begin
              hi_next   = '0;
              lo_next   = '0;
              done_next = 1'b1;
            end
            MDLU_MTHI: begin
              hi_next   = rs;
              done_next = 1'b1;
            end
            MDLU_MTLO: begin
              lo_next   = rs;
              done_next = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_next = step_acc;
        opa_next = step_opa;
        opb_next = step_opb;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
`ifdef MDLU_EARLY_TERM_EN
        if (!div_reg && (step_opb == '0)) state_next = FIX;
`endif
      end
      FIX: begin
        if (div_reg) begin
          lo_next = quo_fixed;
          hi_next = rem_fixed;
        end else begin
          hi_next = prod_fixed[2*WIDTH-1:WIDTH];
          lo_next = prod_fixed[WIDTH-1:0];
        end
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      cnt_reg    <= '0;
      div_reg    <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      acc_reg    <= acc_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      neg_lo_reg <= neg_lo_next;
      neg_hi_reg <= neg_hi_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdlu_seq.sv
// Self-checking bench for mdlu_seq: directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mdlu_seq;
  import libMdluSeq::*;

  localparam int W = 32;
`ifdef MDLU_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  mdlu_op_t       op;
  logic [W-1:0]   rs, rt;
  logic           busy, done;
  logic [W-1:0]   hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] m_hl;

  mdlu_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result as {hi, lo}, from the arithmetic definition of each op.
  function automatic logic [63:0] model(input mdlu_op_t o, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [63:0] cur);
    longint sp;
    int     q, r;
    case (o)
      MDLU_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      MDLU_MULTU: return {32'd0, a} * {32'd0, b};
      MDLU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      MDLU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MDLU_ZERO: return 64'd0;
      MDLU_MTHI: return {a, cur[31:0]};
      MDLU_MTLO: return {cur[63:32], a};
      default:   return cur;
    endcase
  endfunction

  // Edges from the accepting edge until done is visible.
  function automatic int exp_latency(input mdlu_op_t o, input logic [W-1:0] b);
    logic [W-1:0] m;
    int bits;
    if (o == MDLU_ZERO || o == MDLU_MTHI || o == MDLU_MTLO) return 0;
    m = (o == MDLU_MULT && b[W-1]) ? -b : b;
    bits = 1;
    for (int i = 0; i < W; i++) if (m[i]) bits = i + 1;
    if (EARLY && (o == MDLU_MULT || o == MDLU_MULTU)) return bits + 1;
    return W + 1;
  endfunction

  // Entered and left at #1 after a rising edge; returns in the done cycle.
  task automatic run_op(input string tag, input mdlu_op_t o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp_hl, input int exp_lat);
    int lat;
    bit busy_ok;
    op = o; rs = a; rt = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op = mdlu_op_t'(3'($urandom_range(0, 7)));
    rs = $urandom; rt = $urandom;
    lat = -1;
    busy_ok = 1'b1;
    for (int n = 0; n <= W + 5; n++) begin
      if (n > 0) begin @(posedge clock); #1; end
      if (done === 1'b1) begin lat = n; break; end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h latency=%0d", o, a, b, hi, lo, lat);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".hi"}, {32'd0, hi}, {32'd0, exp_hl[63:32]});
    chk({tag, ".lo"}, {32'd0, lo}, {32'd0, exp_hl[31:0]});
    chk({tag, ".busy_at_done"}, {63'd0, busy}, 64'd0);
    if (exp_lat > 0) chk({tag, ".busy_while_running"}, {63'd0, busy_ok}, 64'd1);
  endtask

  typedef struct {
    mdlu_op_t     op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  hl;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int lat, extra, bad;
    logic [W-1:0] a, b;
    mdlu_op_t o;

    tbl[0]  = '{MDLU_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1]  = '{MDLU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2]  = '{MDLU_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
    tbl[3]  = '{MDLU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    tbl[4]  = '{MDLU_DIVU,  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF};
    tbl[5]  = '{MDLU_MTHI,  32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF};
    tbl[6]  = '{MDLU_MTLO,  32'h0000_CAFE, 32'd9,         64'h0000_1234_0000_CAFE};
    tbl[7]  = '{MDLU_MULTU, 32'd5,         32'd3,         64'h0000_0000_0000_000F};
    tbl[8]  = '{MDLU_DIV,   32'hFFFF_FF9C, 32'd0,         64'hFFFF_FF9C_FFFF_FFFF};
    tbl[9]  = '{MDLU_ZERO,  32'hDEAD_BEEF, 32'd1,         64'h0000_0000_0000_0000};
    tbl[10] = '{MDLU_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
    tbl[11] = '{MDLU_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    tbl[12] = '{MDLU_MULT,  32'd5,         32'd0,         64'h0000_0000_0000_0000};
    tbl[13] = '{MDLU_DIVU,  32'hFFFF_FFFF, 32'd10,        64'h0000_0005_1999_9999};
    tbl[14] = '{MDLU_MULT,  32'd7,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};

    reset = 1'b1; start = 1'b0; op = MDLU_ZERO; rs = '0; rt = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.hi", {32'd0, hi}, 64'd0);
    chk("reset.lo", {32'd0, lo}, 64'd0);

    // Consecutive entries start in the previous done cycle (back-to-back).
    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hl,
             exp_latency(tbl[i].op, tbl[i].b));
    m_hl = tbl[14].hl;

    // Undefined opcode: nothing may change.
    op = mdlu_op_t'(3'd7); rs = 32'h5555_5555; rt = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    bad = 0;
    repeat (5) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    $display("op=7 rs=55555555 rt=00000003 -> hi=%h lo=%h (undefined)", hi, lo);
    chk("undef.no_activity", 64'(bad), 64'd0);
    chk("undef.hilo", {hi, lo}, m_hl);

    // Start while busy is ignored and never queued.
    op = MDLU_DIV; rs = 32'd1000; rt = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == 5) begin op = MDLU_MULT; rs = 32'd3; rt = 32'd3; start = 1'b1; end
      @(posedge clock); #1;
      start = 1'b0;
      if (done === 1'b1) begin lat = n; break; end
    end
    $display("op=%0d rs=%h rt=%h -> hi=%h lo=%h latency=%0d (start while busy)", MDLU_DIV, 32'd1000, 32'd7, hi, lo, lat);
    chk("busy_start.latency", 64'(lat), 64'(W + 1));
    chk("busy_start.hilo", {hi, lo}, {32'd6, 32'd142});
    extra = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    chk("busy_start.no_second_op", 64'(extra), 64'd0);

    // Reset mid-divide abandons the operation.
    op = MDLU_DIV; rs = 32'd999; rt = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    chk("midreset.busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midreset.busy", {63'd0, busy}, 64'd0);
    chk("midreset.hilo", {hi, lo}, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    $display("reset during DIV -> hi=%h lo=%h", hi, lo);
    chk("midreset.no_done", 64'(extra), 64'd0);
    m_hl = 64'd0;

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      o = mdlu_op_t'(3'($urandom_range(0, 6)));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 32'($urandom_range(0, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
        chk($sformatf("rnd%0d.done_pulse", i), {63'd0, done}, 64'd0);
      end
      run_op($sformatf("rnd%0d", i), o, a, b, model(o, a, b, m_hl), exp_latency(o, b));
      m_hl = model(o, a, b, m_hl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
